// File: rtl/mult_sched_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mult_sched_if: requester operand handshake and tagged result bus      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface mult_sched_if #(
  parameter int N_REQ   = 4,
  parameter int A_WIDTH = 8,
  parameter int B_WIDTH = 8,
  parameter int O_WIDTH = A_WIDTH + B_WIDTH,
  parameter int ID_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ*A_WIDTH-1:0] req_a;
  logic [N_REQ*B_WIDTH-1:0] req_b;
  logic                     res_valid;
  logic [ID_W-1:0]          res_id;
  logic [O_WIDTH-1:0]       res_data;

  modport master (
    output req_valid, req_a, req_b,
    input  req_ready, res_valid, res_id, res_data
  );

  modport slave (
    input  req_valid, req_a, req_b,
    output req_ready, res_valid, res_id, res_data
  );
endinterface
`default_nettype wire

// File: rtl/mult_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mult_sched: round-robin sharing of one pipelined multiplier with a    |
// | tag pipeline that labels each product with its requester index.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mult_sched #(
  parameter int N_REQ    = 4,
  parameter int A_WIDTH  = 8,
  parameter int B_WIDTH  = 8,
  parameter int O_WIDTH  = A_WIDTH + B_WIDTH,
  parameter int MULT_LAT = 5,
  parameter int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  wire logic               clk_i,
  input  wire logic               rst_i,
  input  wire logic               hold_i,
  mult_sched_if.slave             bus,
  output logic                    mult_en_o,
  output logic [A_WIDTH-1:0]      mult_a_o,
  output logic [B_WIDTH-1:0]      mult_b_o,
  input  wire logic [O_WIDTH-1:0] mult_i,
  output logic                    busy_o
);

  localparam int c_STAGES = MULT_LAT + 1;

  logic [ID_W-1:0]    rr_q, rr_d;
  logic [A_WIDTH-1:0] a_q, a_d;
  logic [B_WIDTH-1:0] b_q, b_d;
  logic [c_STAGES-1:0] tag_vld_q;
  logic [ID_W-1:0]    tag_id_q [c_STAGES];

  logic               found;
  logic [ID_W-1:0]    gnt_id;
  logic [N_REQ-1:0]   gnt;
  logic               accept;
  int                 idx;

  // Search upward from the round-robin pointer, wrapping at N_REQ.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && bus.req_valid[idx[ID_W-1:0]]) begin
        found  = 1'b1;
        gnt_id = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (found && !hold_i && !rst_i) gnt[gnt_id] = 1'b1;
  end

  assign accept = |gnt;

  always_comb begin
    rr_d = rr_q;
    a_d  = a_q;
    b_d  = b_q;
    if (accept) begin
      a_d  = bus.req_a[gnt_id*A_WIDTH +: A_WIDTH];
      b_d  = bus.req_b[gnt_id*B_WIDTH +: B_WIDTH];
      rr_d = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q <= '0;
      a_q  <= '0;
      b_q  <= '0;
    end else begin
      rr_q <= rr_d;
      a_q  <= a_d;
      b_q  <= b_d;
    end
  end

  // Tag stage 0 lines up with the operand register, the rest with the multiplier.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_vld_q <= '0;
      for (int s = 0; s < c_STAGES; s++) tag_id_q[s] <= '0;
    end else if (!hold_i) begin
      tag_vld_q   <= {tag_vld_q[c_STAGES-2:0], accept};
      tag_id_q[0] <= accept ? gnt_id : '0;
      for (int s = 1; s < c_STAGES; s++) tag_id_q[s] <= tag_id_q[s-1];
    end
  end

  assign bus.req_ready = gnt;
  assign bus.res_valid = tag_vld_q[c_STAGES-1] & ~hold_i & ~rst_i;
  assign bus.res_id    = tag_id_q[c_STAGES-1];
  assign bus.res_data  = mult_i;

  assign mult_en_o = ~hold_i | rst_i;
  assign mult_a_o  = a_q;
  assign mult_b_o  = b_q;
  assign busy_o    = |tag_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mult_sched: directed stimulus with a result scoreboard             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mult_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        hold;
  logic        mult_en;
  logic [7:0]  mult_a, mult_b;
  logic [15:0] mult_res;
  logic        busy;
  int          cyc = 0;
  int          errors = 0;
  int          checks = 0;

  typedef struct {
    int          id;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;

  mult_sched_if #(.N_REQ(4), .A_WIDTH(8), .B_WIDTH(8), .O_WIDTH(16)) bus ();

  mult_sched #(
    .N_REQ(4), .A_WIDTH(8), .B_WIDTH(8), .O_WIDTH(16), .MULT_LAT(5)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .hold_i   (hold),
    .bus      (bus),
    .mult_en_o(mult_en),
    .mult_a_o (mult_a),
    .mult_b_o (mult_b),
    .mult_i   (mult_res),
    .busy_o   (busy)
  );

  // Behavioural 5-register signed multiplier with clock enable
  logic signed [15:0] mp [5];
  always_ff @(posedge clk) begin
    if (mult_en) begin
      mp[0] <= $signed(mult_a) * $signed(mult_b);
      for (int i = 1; i < 5; i++) mp[i] <= mp[i-1];
    end
  end
  assign mult_res = mp[4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    checks++;
    if ($countones(bus.req_ready) > 1) begin
      errors++;
      $display("FAIL ready_onehot: got %b required at most one bit", bus.req_ready);
    end
    if (bus.res_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: id=%0d data=%h cycle=%0d, required none",
                 bus.res_id, bus.res_data, cyc);
      end else begin
        e = q.pop_front();
        if (int'(bus.res_id) != e.id || bus.res_data != e.data || cyc != e.cyc) begin
          errors++;
          $display("FAIL result: got id=%0d data=%h cycle=%0d, required id=%0d data=%h cycle=%0d",
                   bus.res_id, bus.res_data, cyc, e.id, e.data, e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // One cycle of stimulus, entered and left at posedge+1.
  task automatic step(input logic [3:0] v, input logic [31:0] a, input logic [31:0] b,
                      input logic h, input logic [3:0] exp_rdy, input bit push,
                      input int id, input logic [15:0] data, input int dly);
    bus.req_valid = v;
    bus.req_a     = a;
    bus.req_b     = b;
    hold          = h;
    @(negedge clk);
    chk("req_ready", {28'd0, bus.req_ready}, {28'd0, exp_rdy});
    chk("mult_en", {31'd0, mult_en}, {31'd0, ~h});
    if (push) q.push_back('{id, data, cyc + dly});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0000, 32'd0, 32'd0, 1'b0, 4'b0000, 1'b0, 0, 16'd0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    hold = 1'b0;
    bus.req_valid = 4'b0000;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_ready", {28'd0, bus.req_ready}, 32'd0);
    chk("rst_mult_en", {31'd0, mult_en}, 32'd1);
    chk("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    chk("rst_res_id", {30'd0, bus.res_id}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_mult_ab", {16'd0, mult_a, mult_b}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    hold = 1'b0;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    do_reset();

    // Single product 3 * -5, busy window
    step(4'b0001, 32'h0000_0003, 32'h0000_00FB, 1'b0, 4'b0001, 1'b1, 0, 16'hFFF1, 6);
    for (int i = 0; i < 7; i++) begin
      bus.req_valid = 4'b0000;
      @(negedge clk);
      chk("busy_window", {31'd0, busy}, (i < 6) ? 32'd1 : 32'd0);
      @(posedge clk);
      #1;
    end

    // All four requesters continuously: rotation 0,1,2,3
    do_reset();
    for (int j = 0; j < 8; j++)
      step(4'b1111, 32'h0403_0201, 32'h0202_0202, 1'b0, 4'(1 << (j % 4)),
           1'b1, j % 4, 16'(2 * (j % 4 + 1)), 6);
    idle(7);

    // Only req2: granted every cycle, pointer ends at 3
    for (int j = 0; j < 5; j++)
      step(4'b0100, 32'h0006_0000, 32'h00FD_0000, 1'b0, 4'b0100, 1'b1, 2, 16'hFFEE, 6);
    step(4'b1111, 32'h0506_0000, 32'h05FD_0000, 1'b0, 4'b1000, 1'b1, 3, 16'h0019, 6);
    idle(6);

    // Operand extremes
    step(4'b0010, 32'h0000_8000, 32'h0000_8000, 1'b0, 4'b0010, 1'b1, 1, 16'h4000, 6);
    step(4'b0001, 32'h0000_007F, 32'h0000_0080, 1'b0, 4'b0001, 1'b1, 0, 16'hC080, 6);
    idle(6);

    // Hold for 3 cycles starting 2 cycles after accept
    step(4'b0010, 32'h0000_0400, 32'h0000_0500, 1'b0, 4'b0010, 1'b1, 1, 16'h0014, 9);
    idle(1);
    for (int j = 0; j < 3; j++)
      step(4'b1111, 32'd0, 32'd0, 1'b1, 4'b0000, 1'b0, 0, 16'd0, 0);
    idle(6);

    // Hold while the result sits in the last stage
    step(4'b0100, 32'h00F9_0000, 32'h0009_0000, 1'b0, 4'b0100, 1'b1, 2, 16'hFFC1, 8);
    idle(5);
    for (int j = 0; j < 2; j++)
      step(4'b0000, 32'd0, 32'd0, 1'b1, 4'b0000, 1'b0, 0, 16'd0, 0);
    idle(3);

    // Reset with three products in flight (pointer is at 3 here)
    step(4'b1111, 32'h0101_0101, 32'h0101_0101, 1'b0, 4'b1000, 1'b0, 0, 16'd0, 0);
    step(4'b1111, 32'h0101_0101, 32'h0101_0101, 1'b0, 4'b0001, 1'b0, 0, 16'd0, 0);
    step(4'b1111, 32'h0101_0101, 32'h0101_0101, 1'b0, 4'b0010, 1'b0, 0, 16'd0, 0);
    idle(1);
    rst = 1'b1;
    hold = 1'b1;
    bus.req_valid = 4'b1111;
    @(negedge clk);
    chk("rst_cycle_ready", {28'd0, bus.req_ready}, 32'd0);
    chk("rst_cycle_mult_en", {31'd0, mult_en}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("busy_after_reset", {31'd0, busy}, 32'd0);
    step(4'b1111, 32'h0000_0009, 32'h0000_00FE, 1'b0, 4'b0001, 1'b1, 0, 16'hFFEE, 6);
    idle(8);

    begin
      int n = 0;
      while (q.size() != 0 && n < 50) begin
        @(posedge clk);
        n++;
      end
    end
    chk("queue_drained", q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mult_sched.md
# mult_sched

Round-robin scheduler that time-shares one pipelined signed multiplier (`mult`, fixed 5-register latency, clock-enable `en_i`) among `N_REQ` requesters in the DDC datapath. It accepts at most one operand pair per cycle through a valid/ready handshake and drives the multiplier inputs. It tracks each in-flight product with a tag pipeline and returns every result tagged with its requester index. Typical use: one multiplier serving several channel mixers or filter taps.

## Interface
- `N_REQ`, default 4: number of requesters, 2..16.
- `A_WIDTH`, default 8: operand A width, signed.
- `B_WIDTH`, default 8: operand B width, signed.
- `O_WIDTH`, default `A_WIDTH+B_WIDTH`: multiplier output width (MSB-aligned slice).
- `MULT_LAT`, default 5: multiplier latency in enabled cycles, from inputs to `mult_o`.
- `ID_W`, default `max(1,$clog2(N_REQ))`: requester index width.

Ports:
- `clk_i`, in, 1: clock, rising edge.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `hold_i`, in, 1: freeze. No grants are issued, the multiplier is disabled and the tag pipeline is frozen.
- `req_valid_i`, in, `N_REQ`: per-requester operand valid.
- `req_ready_o`, out, `N_REQ`: per-requester grant, at most one bit set.
- `req_a_i`, in, `N_REQ*A_WIDTH`: packed operand A. Requester i uses bits `[i*A_WIDTH +: A_WIDTH]`.
- `req_b_i`, in, `N_REQ*B_WIDTH`: packed operand B, same packing.
- `mult_en_o`, out, 1: to multiplier `en_i`.
- `mult_a_o`, out, `A_WIDTH`: to multiplier `a_i`, registered.
- `mult_b_o`, out, `B_WIDTH`: to multiplier `b_i`, registered.
- `mult_i`, in, `O_WIDTH`: from multiplier `mult_o`.
- `res_valid_o`, out, 1: result valid, one-cycle pulse per product.
- `res_id_o`, out, `ID_W`: requester index of the current result.
- `res_data_o`, out, `O_WIDTH`: result, equal to `mult_i` (combinational pass-through).
- `busy_o`, out, 1: at least one product in flight.

## Operation
- Arbitration
  - Round-robin pointer `rr`, range 0..N_REQ-1.
  - Grant goes to the first i with `req_valid_i[i]=1`, searching from `rr` upward and wrapping.
  - `req_ready_o` is combinational from `req_valid_i`, `rr` and `hold_i`. It is all zero when `hold_i=1` or `rst_i=1`.
  - Requesters must not make `req_valid_i` depend on `req_ready_o`.
- Accept: a transfer occurs when `req_valid_i[g] & req_ready_o[g]`. At that clock edge:
  - `mult_a_o`/`mult_b_o` load requester g's operands.
  - `rr` becomes (g+1) mod N_REQ.
  - Tag {valid=1, id=g} enters stage 0 of the tag pipeline.
- No accept: `mult_a_o`/`mult_b_o` hold their values, `rr` holds, and a tag with valid=0 enters stage 0.
- Tag pipeline: `MULT_LAT+1` stages, which matches the operand register plus the multiplier. It advances only when `hold_i=0`.
- Outputs
  - `res_valid_o`/`res_id_o` come from the last tag stage.
  - `res_valid_o` is gated to 0 while `hold_i=1`.
- `mult_en_o = ~hold_i`, and is 1 during reset so the multiplier flushes.
- `busy_o` is the OR of all tag valid bits.
- Arithmetic: operands are passed unmodified; sign handling and truncation are done by the multiplier. `res_data_o` is the top `O_WIDTH` bits of the signed product.

## Timing
- Reset values:
  - `rr=0`, all tags invalid.
  - `mult_a_o=0`, `mult_b_o=0`.
  - `res_valid_o=0`, `res_id_o=0`, `busy_o=0`.
  - `req_ready_o=0`, `mult_en_o=1`.
- Latency: an accept in cycle k gives `res_valid_o=1` in cycle k+1+MULT_LAT (cycle k+6 at defaults), measured in cycles with `hold_i=0`. Results return in accept order.
- Throughput: one product per cycle with any subset of requesters active.
- Fairness: with all N_REQ requesters valid continuously, grants rotate 0,1,…,N_REQ-1,0,…
- Hold: the state at the hold edge is preserved exactly. A result pending in the last stage reappears with the same data on the first cycle after `hold_i` falls.
- Reset mid-operation: all in-flight tags are discarded, with no `res_valid_o` for them. Operands accepted in the reset cycle are not accepted.
- Single requester: it is granted every cycle regardless of `rr`.

## Test plan
- Reset, then req0 issues a=3, b=-5 in cycle 0 -> `res_valid_o=1`, id=0, data=-15 (16-bit 0xFFF1) in cycle 6 only; `busy_o` high in cycles 1..6.
- All 4 requesters valid for 8 cycles, requester i sending a=i+1, b=2 -> ids 0,1,2,3,0,1,2,3 in cycles 6..13, data 2,4,6,8,…; one `req_ready_o` bit per cycle.
- Only req2 valid, 5 consecutive cycles -> 5 grants, 5 results with id=2 in consecutive cycles; `rr` ends at 3.
- Accept a=-128, b=-128 (8-bit) -> data=16384 (0x4000); a=127, b=-128 -> -16256 (0xC080).
- `hold_i` high for 3 cycles starting 2 cycles after an accept -> no grants, `mult_en_o=0`, result arrives 3 cycles late (cycle 9) with the correct value.
- `rst_i` pulsed with 3 products in flight -> no `res_valid_o` for them, `busy_o=0` the cycle after reset, and the next grant goes to req0.
